// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b datapath widths and the memory arbiter state encoding
//   lc3b_word   : 16-bit byte address
//   lc3b_c_line : 128-bit cacheline
//   arb_state_t : arbiter FSM states
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef logic [127:0] lc3b_c_line;
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} arb_state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
//   clk, rst : clock, synchronous active-high reset
//   inc      : count up by one, holding at all-ones
//   clear    : zero the count, overriding a same-cycle inc
//   count    : current value
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk)
    if (rst || clear) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pmem port between I-cache and D-cache, one line at a time
//   i_mem_*     : I-cache miss port (read only)
//   d_mem_*     : D-cache miss port (read or write-back)
//   pmem_*      : physical memory port
//   cnt_clear   : synchronous clear of both miss counters
//   *_miss_count: saturating count of grants per port
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_address,
  output logic [LINE_W-1:0] i_mem_rdata,
  output logic              i_mem_resp,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_address,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              d_mem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  input  logic              cnt_clear,
  output logic [CNT_W-1:0]  i_miss_count,
  output logic [CNT_W-1:0]  d_miss_count
);
  arb_state_t state, state_n;
  logic last_d, grant_i, grant_d, serve;
  always_ff @(posedge clk)
    if (rst) begin
      state  <= IDLE;
      last_d <= 1'b0;
    end else begin
      state  <= state_n;
      last_d <= grant_d ? 1'b1 : grant_i ? 1'b0 : last_d;
    end
  // On a tie the port that did not win last time gets the grant
  always_comb begin
    serve   = state == SERVE_I || state == SERVE_D;
    grant_d = state == IDLE && (d_mem_read || d_mem_write) && (!i_mem_read || !last_d);
    grant_i = state == IDLE && i_mem_read && !grant_d;
    state_n = grant_i ? SERVE_I :
              grant_d ? SERVE_D :
              serve   ? (pmem_resp ? RELEASE : state) :
              IDLE;
  end
  // A D request with both strobes set is a write-back; the read is dropped
  assign pmem_read    = state == SERVE_I ? i_mem_read : state == SERVE_D && d_mem_read && !d_mem_write;
  assign pmem_write   = state == SERVE_D && d_mem_write;
  assign pmem_address = state == SERVE_D ? d_mem_address : i_mem_address;
  assign pmem_wdata   = d_mem_wdata;
  assign i_mem_rdata  = pmem_rdata;
  assign d_mem_rdata  = pmem_rdata;
  assign i_mem_resp   = state == SERVE_I && pmem_resp;
  assign d_mem_resp   = state == SERVE_D && pmem_resp;
  sat_counter #(.CNT_W(CNT_W)) u_i_cnt (.clk(clk), .rst(rst), .inc(grant_i), .clear(cnt_clear), .count(i_miss_count));
  sat_counter #(.CNT_W(CNT_W)) u_d_cnt (.clk(clk), .rst(rst), .inc(grant_d), .clear(cnt_clear), .count(d_miss_count));
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table plus scoreboarded sequences for mem_arbiter
module tb_mem_arbiter;
  import lc3b_types::*;
  logic clk = 1'b0;
  logic rst, i_mem_read, d_mem_read, d_mem_write, pmem_resp, cnt_clear;
  logic i_mem_resp, d_mem_resp, pmem_read, pmem_write;
  lc3b_word i_mem_address, d_mem_address, pmem_address;
  lc3b_c_line d_mem_wdata, pmem_rdata, i_mem_rdata, d_mem_rdata, pmem_wdata;
  logic [15:0] i_miss_count, d_miss_count;
  logic s_i_resp, s_d_resp, s_pread, s_pwrite;
  lc3b_word s_paddr;
  lc3b_c_line s_i_rdata, s_d_rdata, s_pwdata;
  logic [2:0] s_ic, s_dc;
  int passed = 0, total = 0;
  localparam lc3b_c_line WD = {8{16'hBEEF}};
  always #5 clk = ~clk;
  mem_arbiter u_dut (
    .clk(clk), .rst(rst),
    .i_mem_read(i_mem_read), .i_mem_address(i_mem_address), .i_mem_rdata(i_mem_rdata), .i_mem_resp(i_mem_resp),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_address(d_mem_address), .d_mem_wdata(d_mem_wdata),
    .d_mem_rdata(d_mem_rdata), .d_mem_resp(d_mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .cnt_clear(cnt_clear), .i_miss_count(i_miss_count), .d_miss_count(d_miss_count)
  );
  mem_arbiter #(.CNT_W(3)) u_sat (
    .clk(clk), .rst(rst),
    .i_mem_read(i_mem_read), .i_mem_address(i_mem_address), .i_mem_rdata(s_i_rdata), .i_mem_resp(s_i_resp),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_address(d_mem_address), .d_mem_wdata(d_mem_wdata),
    .d_mem_rdata(s_d_rdata), .d_mem_resp(s_d_resp),
    .pmem_read(s_pread), .pmem_write(s_pwrite), .pmem_address(s_paddr), .pmem_wdata(s_pwdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .cnt_clear(cnt_clear), .i_miss_count(s_ic), .d_miss_count(s_dc)
  );
  typedef struct {
    logic r, ir, dr, dw, pr, cl;
    logic [15:0] ia, da;
    logic epr, epw, eir, edr;
    logic [15:0] ea;
    int eic, edc;
  } vec_t;
  vec_t tbl[$];
  lc3b_word q[$];
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask
  function automatic vec_t mk(input logic r, ir, input logic [15:0] ia, input logic dr, dw, input logic [15:0] da,
                              input logic pr, cl, epr, epw, input logic [15:0] ea, input logic eir, edr,
                              input int eic, edc);
    vec_t v;
    v.r = r; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.pr = pr; v.cl = cl;
    v.epr = epr; v.epw = epw; v.ea = ea; v.eir = eir; v.edr = edr; v.eic = eic; v.edc = edc;
    return v;
  endfunction
  task automatic wait_strobe(output int n, inout int spurious);
    n = 0;
    while (!(pmem_read || pmem_write) && n < 10) begin
      @(posedge clk); #1;
      n++;
      if (!(pmem_read || pmem_write) && (i_mem_resp || d_mem_resp)) spurious++;
    end
  endtask
  task automatic finish_txn(input logic is_d);
    pmem_resp = 1'b1; #1;
    chk("resp_own", is_d ? d_mem_resp : i_mem_resp, 1'b1);
    chk("resp_other", is_d ? i_mem_resp : d_mem_resp, 1'b0);
    @(posedge clk); #1;
    pmem_resp = 1'b0;
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    int n, spurious;
    vec_t v;
    rst = 1'b1; i_mem_read = 0; d_mem_read = 0; d_mem_write = 0; pmem_resp = 0; cnt_clear = 0;
    i_mem_address = 0; d_mem_address = 0; d_mem_wdata = WD; pmem_rdata = 0;
    //           r  ir ia       dr dw da       pr cl  epr epw ea       eir edr ic dc
    tbl.push_back(mk(0, 1, 16'h1230, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 16'h1230, 0, 0, 16'h0000, 0, 0, 1, 0, 16'h1230, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 16'h1230, 0, 0, 16'h0000, 0, 0, 1, 0, 16'h1230, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 16'h1230, 0, 0, 16'h0000, 0, 0, 1, 0, 16'h1230, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 16'h1230, 0, 0, 16'h0000, 1, 0, 1, 0, 16'h1230, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 16'h0040, 0, 1, 16'h8000, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 16'h0040, 0, 1, 16'h8000, 0, 0, 0, 1, 16'h8000, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 16'h0040, 0, 1, 16'h8000, 1, 0, 0, 1, 16'h8000, 0, 1, 1, 1));
    tbl.push_back(mk(0, 1, 16'h0040, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 16'h0040, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 16'h0040, 0, 0, 16'h0000, 0, 0, 1, 0, 16'h0040, 0, 0, 2, 1));
    tbl.push_back(mk(0, 1, 16'h0040, 0, 0, 16'h0000, 1, 0, 1, 0, 16'h0040, 1, 0, 2, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 2, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 2, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h2000, 0, 0, 0, 0, 16'h0000, 0, 0, 2, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h2000, 0, 0, 0, 1, 16'h2000, 0, 0, 2, 2));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h2000, 1, 0, 0, 1, 16'h2000, 0, 1, 2, 2));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 2, 2));
    tbl.push_back(mk(0, 1, 16'h0040, 1, 0, 16'h3000, 0, 0, 0, 0, 16'h0000, 0, 0, 2, 2));
    tbl.push_back(mk(0, 1, 16'h0040, 1, 0, 16'h3000, 0, 0, 1, 0, 16'h0040, 0, 0, 3, 2));
    tbl.push_back(mk(0, 1, 16'h0040, 1, 0, 16'h3000, 1, 0, 1, 0, 16'h0040, 1, 0, 3, 2));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h3000, 0, 0, 0, 0, 16'h0000, 0, 0, 3, 2));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h3000, 0, 0, 0, 0, 16'h0000, 0, 0, 3, 2));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h3000, 0, 0, 1, 0, 16'h3000, 0, 0, 3, 3));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h3000, 1, 0, 1, 0, 16'h3000, 0, 1, 3, 3));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 3, 3));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 0, 3, 3));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 3, 3));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h4000, 0, 0, 0, 0, 16'h0000, 0, 0, 3, 3));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h4000, 0, 0, 1, 0, 16'h4000, 0, 0, 3, 4));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 16'h4000, 0, 0, 1, 0, 16'h4000, 0, 0, 3, 4));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 16'h0040, 1, 0, 16'h6000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 16'h0040, 1, 0, 16'h6000, 0, 0, 1, 0, 16'h6000, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 16'h0040, 1, 0, 16'h6000, 1, 0, 1, 0, 16'h6000, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      @(negedge clk);
      rst = v.r; i_mem_read = v.ir; i_mem_address = v.ia; d_mem_read = v.dr; d_mem_write = v.dw;
      d_mem_address = v.da; pmem_resp = v.pr; cnt_clear = v.cl;
      pmem_rdata = (i == 4) ? {16{8'hA5}} : {$urandom, $urandom, $urandom, $urandom};
      #1;
      chk($sformatf("v%0d_pmem_read", i), pmem_read, v.epr);
      chk($sformatf("v%0d_pmem_write", i), pmem_write, v.epw);
      if (v.epr || v.epw) chk($sformatf("v%0d_pmem_address", i), pmem_address, v.ea);
      if (v.epw) chk($sformatf("v%0d_pmem_wdata", i), pmem_wdata, WD);
      chk($sformatf("v%0d_i_resp", i), i_mem_resp, v.eir);
      chk($sformatf("v%0d_d_resp", i), d_mem_resp, v.edr);
      chk($sformatf("v%0d_i_cnt", i), i_miss_count, v.eic[15:0]);
      chk($sformatf("v%0d_d_cnt", i), d_miss_count, v.edc[15:0]);
      chk($sformatf("v%0d_i_rdata", i), i_mem_rdata, pmem_rdata);
      chk($sformatf("v%0d_d_rdata", i), d_mem_rdata, pmem_rdata);
    end
    // saturation: 3-bit instance saturates at 7 while the 16-bit one keeps counting
    @(posedge clk); #1;
    rst = 1'b1; i_mem_read = 0; d_mem_read = 0; d_mem_write = 0; pmem_resp = 0; cnt_clear = 0;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    chk("sat_reset_s", s_ic, 3'd0);
    i_mem_read = 1'b1; i_mem_address = 16'h0100;
    spurious = 0;
    for (int t = 1; t <= 9; t++) begin
      wait_strobe(n, spurious);
      chk($sformatf("sat_wait%0d", t), n < 10, 1'b1);
      chk($sformatf("sat_big%0d", t), i_miss_count, t);
      chk($sformatf("sat_small%0d", t), s_ic, t > 7 ? 7 : t);
      finish_txn(1'b0);
    end
    @(posedge clk); #1;
    cnt_clear = 1'b1;
    @(posedge clk); #1;
    cnt_clear = 1'b0;
    chk("clr_grant_strobe", pmem_read, 1'b1);
    chk("clr_big", i_miss_count, 16'd0);
    chk("clr_small", s_ic, 3'd0);
    finish_txn(1'b0);
    i_mem_read = 1'b0;
    // back-to-back D reads held continuously
    d_mem_read = 1'b1;
    q.delete();
    for (int k = 0; k < 4; k++) begin
      d_mem_address = 16'h5000 + 16'(k * 16);
      q.push_back(d_mem_address);
      wait_strobe(n, spurious);
      chk($sformatf("b2b_gap%0d", k), n, 2);
      chk($sformatf("b2b_sb_nonempty%0d", k), q.size() > 0, 1'b1);
      if (q.size() > 0) chk($sformatf("b2b_addr%0d", k), pmem_address, q.pop_front());
      chk($sformatf("b2b_dcnt%0d", k), d_miss_count, k + 1);
      finish_txn(1'b1);
    end
    d_mem_read = 1'b0;
    chk("b2b_no_i_grants", i_miss_count, 16'd0);
    chk("no_spurious_resp", spurious, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
